// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind the UART receiver.
// Turns HEAD0 HEAD1 ADDR DATA CHK byte frames into single register-write pulses.
module uart_cmd_parser #(
  parameter logic [7:0]  HEAD0   = 8'h55,
  parameter logic [7:0]  HEAD1   = 8'hAA,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       addr_q, addr_nxt;
  logic [7:0]       data_q, data_nxt;
  logic [7:0]       sum;
  logic             wr_en_nxt, err_nxt;
  logic [7:0]       wr_addr_nxt, wr_data_nxt;
  logic [1:0]       err_code_nxt;

  assign busy = (state != S_IDLE);
  assign sum  = addr_q + data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      err      <= err_nxt;
      err_code <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    err_nxt      = 1'b0;
    err_code_nxt = err_code;

    // A byte always takes precedence over a coincident timeout expiry.
    if (rx_vld) begin
      cnt_nxt = '0;
      case (state)
        S_IDLE: if (rx_data == HEAD0) state_nxt = S_H1;
        S_H1: begin
          if (rx_data == HEAD1)      state_nxt = S_ADDR;
          else if (rx_data == HEAD0) state_nxt = S_H1;
          else                       state_nxt = S_IDLE;
        end
        S_ADDR: begin
          addr_nxt  = rx_data;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          data_nxt  = rx_data;
          state_nxt = S_CHK;
        end
        S_CHK: begin
          state_nxt = S_IDLE;
          if (rx_data == sum) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_q;
            wr_data_nxt = data_q;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'b01;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state == S_IDLE) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
      state_nxt    = S_IDLE;
      cnt_nxt      = '0;
      err_nxt      = 1'b1;
      err_code_nxt = 2'b10;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected wr_en/err events,
// a negedge monitor pops and checks them against what the DUT presents.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_vld = 1'b0;
  logic [7:0] rx_data = '0;
  logic       wr_en, err, busy;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_cmd_parser #(
    .HEAD0  (8'h55),
    .HEAD1  (8'hAA),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_vld  (rx_vld),
    .rx_data (rx_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err     (err),
    .err_code(err_code),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         neg_cnt = 0;
  logic [7:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic [7:0] cur_addr = '0;
  logic [7:0] cur_data = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_err, input logic [1:0] code, input int delay);
    exp_t e;
    e.is_err = is_err;
    e.addr   = last_addr;
    e.data   = last_data;
    e.code   = code;
    e.due    = neg_cnt + delay;
    q.push_back(e);
  endtask

  // Drives one byte; rx_vld is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_vld  = 1'b0;
  endtask

  // Full frame; the model decides good vs checksum error itself.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    send_byte(c);
    if (c == 8'(a + d)) begin
      last_addr = a;
      last_data = d;
      push(1'b0, 2'b00, 1);
    end else begin
      push(1'b1, 2'b01, 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (rst_n) begin
      if (wr_en && err) check("wr_en_err_exclusive", 1, 0);
      while (q.size() > 0 && q[0].due < neg_cnt) begin
        e = q.pop_front();
        check(e.is_err ? "missing_err" : "missing_wr_en", 0, 1);
      end
      if (wr_en || err) begin
        if (q.size() == 0) begin
          check(wr_en ? "unexpected_wr_en" : "unexpected_err", 1, 0);
        end else begin
          e = q.pop_front();
          check("event_kind_err", int'(err), int'(e.is_err));
          check("event_latency", neg_cnt, e.due);
          check("wr_addr", int'(wr_addr), int'(e.addr));
          check("wr_data", int'(wr_data), int'(e.data));
          if (e.is_err) check("err_code", int'(err_code), int'(e.code));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_err", int'(err), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_err_code", int'(err_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame with busy tracking.
    send_byte(8'h55); check("busy_after_h0", int'(busy), 1);
    send_byte(8'hAA); check("busy_after_h1", int'(busy), 1);
    send_byte(8'h12); check("busy_after_addr", int'(busy), 1);
    send_byte(8'h34); check("busy_after_data", int'(busy), 1);
    send_byte(8'h46); check("busy_at_wr_en", int'(busy), 0);
    last_addr = 8'h12;
    last_data = 8'h34;
    push(1'b0, 2'b00, 1);
    idle(3);

    // Bad checksum: held outputs must keep 12/34.
    send_frame(8'h12, 8'h34, 8'h47);
    idle(3);

    // Timeout after ADDR, then a fresh frame.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h12);
    push(1'b1, 2'b10, TO + 1);
    idle(TO);
    check("busy_after_timeout", int'(busy), 0);
    idle(2);
    send_frame(8'h01, 8'h02, 8'h03);
    idle(3);

    // Resynchronisation on repeated / broken headers.
    send_byte(8'h55);
    send_frame(8'h07, 8'h08, 8'h0F);
    idle(2);
    send_byte(8'h55);
    send_byte(8'h13);
    send_frame(8'h07, 8'h08, 8'h0F);
    idle(3);

    // Checksum wrap-around.
    send_frame(8'hFF, 8'h02, 8'h01);
    idle(3);

    // Byte arriving exactly on the expiry cycle is accepted.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h80);
    idle(TO - 1);
    send_byte(8'h90);
    check("busy_after_late_byte", int'(busy), 1);
    send_byte(8'h10);
    last_addr = 8'h80;
    last_data = 8'h90;
    push(1'b0, 2'b00, 1);
    idle(3);

    // Back-to-back frames: second starts in the wr_en cycle.
    send_frame(8'h21, 8'h22, 8'h43);
    send_frame(8'h31, 8'h32, 8'h00);
    idle(3);

    // Asynchronous reset mid-frame.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_err_code", int'(err_code), 0);
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h34);
    send_byte(8'h46);
    idle(TO + 4);
    send_frame(8'h5A, 8'h06, 8'h60);
    idle(4);

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
